// File: rtl/led_level_driver_pkg.sv
// Shared constants for the LED level driver: display mode encodings, PWM width and the duty compare.
package led_level_driver_pkg;

    localparam int PWM_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        MODE_DIM     = 2'd0,
        MODE_BAR     = 2'd1,
        MODE_BIN     = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    function automatic logic pwm_on(input logic [7:0] cnt, input logic [7:0] duty);
        return (cnt < duty);
    endfunction

endpackage

// File: rtl/led_level_driver_timebase.sv
// PWM timebase: a free-running prescaler that produces one step tick, and the 256-step period counter.
module pwm_timebase #(
    parameter int PRESCALE_BITS = 6,
    parameter int PWM_BITS      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                tick,
    output logic                period_end
);

    logic [PRESCALE_BITS-1:0] presc_q, presc_d;
    logic [PWM_BITS-1:0]      cnt_q, cnt_d;

    always_comb begin
        tick       = (presc_q == {PRESCALE_BITS{1'b1}});
        period_end = tick && (cnt_q == {PWM_BITS{1'b1}});
        presc_d    = presc_q + PRESCALE_BITS'(1);
        cnt_d      = cnt_q;
        if (tick) begin
            cnt_d = cnt_q + PWM_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pwm_cnt = cnt_q;

endmodule

// File: rtl/led_level_driver.sv
// Maps the rotary encoder level onto four LEDs in one of three display modes selected by the pushbutton.
module led_level_driver
    import led_level_driver_pkg::*;
#(
    parameter int PRESCALE_BITS = 6,
    parameter int PWM_BITS      = PWM_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] level,
    input  logic       btn_n,
    output logic [3:0] leds,
    output logic [1:0] mode
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                period_end;

    mode_e      mode_q, mode_d;
    logic [7:0] level_q, level_d;
    logic [3:0] leds_q, leds_d;
    logic       btn_prev_q, btn_prev_d;
    logic       armed_q, armed_d;
    logic       press;
    logic [1:0] bar_n;
    logic [7:0] bar_f;
    logic [3:0] bar_bits;
    logic       dim_on;

    pwm_timebase #(
        .PRESCALE_BITS(PRESCALE_BITS),
        .PWM_BITS     (PWM_BITS)
    ) u_timebase (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_cnt   (pwm_cnt),
        .tick      (tick),
        .period_end(period_end)
    );

    assign bar_n  = level_q[7:6];
    assign bar_f  = {level_q[5:0], 2'b00};
    assign dim_on = pwm_on(pwm_cnt, level_q);

    // Bar graph: fully lit below the partial LED, PWM-dimmed at it, dark above it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bar
            assign bar_bits[gi] = (2'(gi) < bar_n)  ? 1'b1 :
                                  (2'(gi) == bar_n) ? pwm_on(pwm_cnt, bar_f) : 1'b0;
        end
    endgenerate

    // A button already held at reset must be seen released before a press can count.
    assign press = armed_q && btn_prev_q && !btn_n;

    always_comb begin
        mode_d     = mode_q;
        level_d    = level_q;
        btn_prev_d = btn_n;
        armed_d    = armed_q || btn_n;
        leds_d     = 4'b0000;

        if (tick && period_end) begin
            level_d = level;
        end

        if (mode_q == MODE_ILLEGAL) begin
            mode_d = MODE_DIM;
        end else if (press) begin
            case (mode_q)
                MODE_DIM: mode_d = MODE_BAR;
                MODE_BAR: mode_d = MODE_BIN;
                default:  mode_d = MODE_DIM;
            endcase
        end

        case (mode_q)
            MODE_DIM: leds_d = {4{dim_on}};
            MODE_BAR: leds_d = bar_bits;
            MODE_BIN: leds_d = level[3:0];
            default:  leds_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_DIM;
            level_q    <= 8'h00;
            leds_q     <= 4'b0000;
            btn_prev_q <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            level_q    <= level_d;
            leds_q     <= leds_d;
            btn_prev_q <= btn_prev_d;
            armed_q    <= armed_d;
        end
    end

    assign leds = leds_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_level_driver.sv
// Scoreboarded bench for led_level_driver with PRESCALE_BITS = 1 (512-clock PWM period).
module tb_led_level_driver;

    localparam int R = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] level;
    logic       btn_n;
    logic [3:0] leds;
    logic [1:0] mode;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        int         start;
        int         len;
        logic [5:0] mask;
        logic [5:0] pat;
        int         count;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   active = 1'b0;
    int   hits = 0;
    int   left = 0;

    led_level_driver #(.PRESCALE_BITS(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .level(level),
        .btn_n(btn_n),
        .leds (leds),
        .mode (mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: over each expected window, count cycles whose masked {mode,leds} equals the pattern.
    always @(negedge clk) begin
        if (!active && sb.size() > 0 && cyc >= sb[0].start) begin
            cur    = sb.pop_front();
            active = 1'b1;
            hits   = 0;
            left   = cur.len;
        end
        if (active) begin
            if ((({mode, leds}) & cur.mask) == cur.pat) hits++;
            left--;
            if (left == 0) begin
                checks++;
                active = 1'b0;
                if (hits != cur.count) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: matching cycles=%0d required=%0d (pattern %h mask %h, last mode=%0d leds=%b)",
                             cur.name, cyc, hits, cur.count, cur.pat, cur.mask, mode, leds);
                end else begin
                    $display("check %s @cyc %0d: matching cycles=%0d of %0d ok", cur.name, cyc, hits, cur.len);
                end
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string name, input int start, input int len,
                        input logic [5:0] mask, input logic [5:0] pat, input int count);
        exp_t e;
        e.name = name; e.start = start; e.len = len;
        e.mask = mask; e.pat = pat; e.count = count;
        sb.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        btn_n = 1'b1;
        level = 8'h80;

        wait_cyc(R);
        push("reset_state", R, 1, 6'h3F, 6'h00, 1);
        rst_n = 1'b1;
        push("first_period_dark", R + 1,   512, 6'h0F, 6'h00, 512);
        push("half_duty_on",      R + 513, 256, 6'h0F, 6'h0F, 256);
        push("half_duty_off",     R + 769, 256, 6'h0F, 6'h00, 256);

        // Mid-period level change must not disturb the running half-duty period.
        wait_cyc(R + 600);
        level = 8'h00;
        push("level00_dark", R + 1025, 512, 6'h0F, 6'h00, 512);

        wait_cyc(R + 1100);
        level = 8'hFF;
        push("levelFF_on",  R + 1537, 510, 6'h0F, 6'h0F, 510);
        push("levelFF_gap", R + 2047, 2,   6'h0F, 6'h00, 2);

        // Three short presses: DIM -> BAR -> BIN -> DIM.
        wait_cyc(R + 2100);
        push("press1_before", R + 2100, 1,  6'h30, 6'h00, 1);
        push("press1_bar",    R + 2101, 50, 6'h30, 6'h10, 50);
        push("press2_bin",    R + 2151, 50, 6'h30, 6'h20, 50);
        push("press3_dim",    R + 2201, 1,  6'h30, 6'h00, 1);
        btn_n = 1'b0;
        wait_cyc(R + 2110); btn_n = 1'b1;
        wait_cyc(R + 2150); btn_n = 1'b0;
        wait_cyc(R + 2160); btn_n = 1'b1;
        wait_cyc(R + 2200); btn_n = 1'b0;
        wait_cyc(R + 2210); btn_n = 1'b1;

        // Long hold: exactly one advance.
        wait_cyc(R + 2300);
        push("hold_before", R + 2300, 1,    6'h30, 6'h00, 1);
        push("hold_once",   R + 2301, 1100, 6'h30, 6'h10, 1100);
        btn_n = 1'b0;
        wait_cyc(R + 3000);
        level = 8'hA0;
        push("barA0_lit_half", R + 3585, 256, 6'h3F, 6'h17, 256);
        push("barA0_dim_half", R + 3841, 256, 6'h3F, 6'h13, 256);
        wait_cyc(R + 3300);
        btn_n = 1'b1;

        wait_cyc(R + 3700);
        level = 8'hC0;
        push("barC0_steady", R + 4097, 512, 6'h3F, 6'h17, 512);

        // BIN mode: leds follow level[3:0] with one clock of latency.
        wait_cyc(R + 4700);
        push("press_to_bin", R + 4701, 1, 6'h30, 6'h20, 1);
        btn_n = 1'b0;
        wait_cyc(R + 4710); btn_n = 1'b1;
        wait_cyc(R + 4750);
        level = 8'h05;
        push("bin_05",        R + 4751, 1, 6'h3F, 6'h25, 1);
        wait_cyc(R + 4760);
        push("bin_05_held",   R + 4760, 1, 6'h3F, 6'h25, 1);
        push("bin_0A",        R + 4761, 1, 6'h3F, 6'h2A, 1);
        level = 8'h0A;

        // Back to BAR, then reset mid-period with the button held.
        wait_cyc(R + 4800);
        push("press_to_dim", R + 4801, 1, 6'h30, 6'h00, 1);
        btn_n = 1'b0;
        wait_cyc(R + 4810); btn_n = 1'b1;
        wait_cyc(R + 4850);
        push("press_to_bar", R + 4851, 1, 6'h30, 6'h10, 1);
        btn_n = 1'b0;
        wait_cyc(R + 4900);
        push("midreset_state",   R + 4901, 1,   6'h3F, 6'h00, 1);
        push("after_reset_held", R + 4906, 200, 6'h3F, 6'h00, 200);
        rst_n = 1'b0;
        wait_cyc(R + 4905);
        rst_n = 1'b1;
        wait_cyc(R + 4950);
        btn_n = 1'b1;

        begin
            int budget = 2000;
            while ((sb.size() > 0 || active) && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (budget == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
